lock_controller: RTL
====================

# lock_controller

Sequential access-control stage sitting directly downstream of the password comparator stage. It consumes the comparator's combinational equality flag when the user submits an attempt, then drives the unlock, error and lockout outputs. It counts consecutive failed attempts and enforces a timed lockout once a limit is reached. An optional alarm output is available during lockout.

## Interface
- `MAX_TRIES`, default 3: consecutive failures that trigger lockout (≥1).
- `OPEN_CYCLES`, default 8: cycles UNLOCK stays high per successful attempt (≥1).
- `LOCKOUT_CYCLES`, default 16: cycles the lockout lasts (≥1).
- `CLK` input, 1 bit: the single clock, rising edge.
- `RST` input, 1 bit: reset, asynchronous, active-high.
- `CHECK` input, 1 bit: attempt-submit strobe; sampled on each rising edge.
- `EQUAL` input, 1 bit: equality flag from the comparator; valid in the same cycle as CHECK.
- `UNLOCK` output, 1 bit: lock open.
- `ERR` output, 1 bit: one-cycle pulse for a rejected attempt.
- `LOCKED_OUT` output, 1 bit: lockout in progress.
- `ALARM` output, 1 bit: alarm indicator (see Configuration).
- `BUSY` output, 1 bit: high in any state other than IDLE; CHECK is ignored while BUSY.
- `FAIL_CNT` output, `$clog2(MAX_TRIES+1)` bits: current count of consecutive failures.

## Operation
- FSM states: IDLE, OPEN, FAIL, LOCKOUT. All outputs are registered, except BUSY, which is decoded from the state.
- **IDLE, CHECK=1, EQUAL=1:**
  - go to OPEN;
  - clear FAIL_CNT to 0;
  - load the cycle counter with OPEN_CYCLES-1.
- **IDLE, CHECK=1, EQUAL=0, FAIL_CNT+1 < MAX_TRIES:**
  - go to FAIL;
  - increment FAIL_CNT.
- **IDLE, CHECK=1, EQUAL=0, FAIL_CNT+1 == MAX_TRIES:**
  - go to LOCKOUT;
  - set FAIL_CNT to MAX_TRIES;
  - load the cycle counter with LOCKOUT_CYCLES-1.
- **IDLE, CHECK=0:** stay in IDLE; EQUAL is ignored.
- **FAIL:** unconditionally return to IDLE after one cycle.
- **OPEN:**
  - UNLOCK=1;
  - the counter decrements each cycle;
  - at counter==0, go to IDLE.
- **LOCKOUT:**
  - LOCKED_OUT=1;
  - the counter decrements each cycle;
  - at counter==0, go to IDLE and clear FAIL_CNT.
- CHECK pulses in OPEN, FAIL or LOCKOUT are dropped. They are not queued, and FAIL_CNT is unaffected.
- A held-high CHECK counts as a new attempt on each IDLE cycle in which it is sampled.
- Cycle counter width: `$clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES))`, minimum 1 bit. It never wraps: it is reloaded only on state entry.
- **Reset (any time, including mid-OPEN or mid-LOCKOUT):**
  - state IDLE;
  - FAIL_CNT=0, counter=0;
  - UNLOCK=0, ERR=0, LOCKED_OUT=0, ALARM=0, BUSY=0.

## Timing
- Let edge N be the rising edge at which CHECK=1 is sampled in IDLE.
- **Success:**
  - UNLOCK is high from after edge N to after edge N+OPEN_CYCLES, i.e. exactly OPEN_CYCLES cycles;
  - a new CHECK is accepted at edge N+OPEN_CYCLES+1 at the earliest.
- **Failure (no lockout):**
  - ERR is high for exactly the one cycle after edge N;
  - the next CHECK is accepted at edge N+2 at the earliest.
- **Lockout:**
  - LOCKED_OUT is high for exactly LOCKOUT_CYCLES cycles after edge N;
  - FAIL_CNT reads MAX_TRIES during lockout and 0 afterwards;
  - ERR is not pulsed on the locking attempt.
- **Latency** from CHECK to the first output change: 1 cycle.
- **RST deassertion:** the first CHECK can be sampled at the next rising edge.

## Configuration
- Macro: `LOCK_ALARM_EN`.
- **Defined:**
  - ALARM is a registered copy of the lockout condition: high exactly while LOCKED_OUT is high;
  - in addition, ALARM pulses for one cycle on every CHECK that arrives during LOCKOUT (tamper indication).
- **Undefined:**
  - ALARM is tied to 0;
  - no alarm logic is synthesised.

## Test plan
- **Correct password:** reset, then CHECK=1 with EQUAL=1 for one cycle.
  - Required: UNLOCK high for 8 cycles, FAIL_CNT=0, BUSY high for 8 cycles, then IDLE.
- **Two wrong attempts, then correct:** two CHECKs with EQUAL=0, spaced 3 cycles apart.
  - Required: two ERR pulses, FAIL_CNT goes 1 then 2.
  - Then a CHECK with EQUAL=1: UNLOCK for 8 cycles and FAIL_CNT back to 0.
- **Lockout:** three wrong attempts.
  - Required: the third attempt gives no ERR; LOCKED_OUT high for 16 cycles with FAIL_CNT=3; afterwards FAIL_CNT=0.
  - A CHECK with EQUAL=1 during LOCKOUT has no effect on UNLOCK.
- **Reset mid-operation:** assert RST asynchronously (between edges) at cycle 4 of OPEN and at cycle 10 of LOCKOUT.
  - Required: all outputs 0 immediately; FAIL_CNT=0; the next CHECK with EQUAL=1 unlocks normally.
- **CHECK while BUSY:** CHECK held high through an entire OPEN window.
  - Required: no extra attempts counted during OPEN.
  - A new attempt is taken on the first IDLE cycle: with EQUAL=1 it re-enters OPEN.
- **`LOCK_ALARM_EN` defined vs undefined:**
  - Defined: ALARM tracks LOCKED_OUT, plus a 1-cycle pulse per CHECK during lockout.
  - Undefined: ALARM stays 0 throughout the lockout scenario.

Source files
------------

// File: rtl/lock_controller.sv
// Access-control FSM: acts on the comparator's EQUAL flag when CHECK is sampled in IDLE.
// It drives UNLOCK, ERR and LOCKED_OUT, and enforces a timed lockout after repeated failures.
// `LOCK_ALARM_EN adds the ALARM output. When the macro is undefined, ALARM is tied to 0.
module lock_controller #(
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             CHECK,
  input  logic                             EQUAL,
  output logic                             UNLOCK,
  output logic                             ERR,
  output logic                             LOCKED_OUT,
  output logic                             ALARM,
  output logic                             BUSY,
  output logic [$clog2(MAX_TRIES+1)-1:0]   FAIL_CNT
);

  localparam int FC_W    = $clog2(MAX_TRIES+1);
  localparam int CNT_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, OPEN, FAIL, LOCKOUT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_try;
  logic             lock_enter;

  assign BUSY       = (state != IDLE);
  // The attempt that reaches MAX_TRIES locks out instead of pulsing ERR.
  assign last_try   = (int'(FAIL_CNT) + 1) >= MAX_TRIES;
  assign lock_enter = (state == IDLE) && CHECK && !EQUAL && last_try;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      FAIL_CNT   <= '0;
      UNLOCK     <= 1'b0;
      ERR        <= 1'b0;
      LOCKED_OUT <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        IDLE: if (CHECK) begin
          if (EQUAL) begin
            state    <= OPEN;
            FAIL_CNT <= '0;
            cnt      <= CNT_W'(OPEN_CYCLES - 1);
            UNLOCK   <= 1'b1;
          end else if (last_try) begin
            state      <= LOCKOUT;
            FAIL_CNT   <= FC_W'(MAX_TRIES);
            cnt        <= CNT_W'(LOCKOUT_CYCLES - 1);
            LOCKED_OUT <= 1'b1;
          end else begin
            state    <= FAIL;
            FAIL_CNT <= FAIL_CNT + FC_W'(1);
            ERR      <= 1'b1;
          end
        end
        FAIL: state <= IDLE;
        OPEN: begin
          if (cnt == '0) begin
            state  <= IDLE;
            UNLOCK <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOCKOUT: begin
          if (cnt == '0) begin
            state      <= IDLE;
            LOCKED_OUT <= 1'b0;
            FAIL_CNT   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOCK_ALARM_EN
  // Follows next-cycle LOCKED_OUT. A CHECK during lockout (tamper) also raises it for one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ALARM <= 1'b0;
    else     ALARM <= lock_enter || ((state == LOCKOUT) && ((cnt != '0) || CHECK));
  end
`else
  assign ALARM = 1'b0;
`endif

endmodule
